rf_wb_arbiter: RTL and testbench

Write-back controller for the integer register file. Shares the register file's single write port between two result producers (EXU and LSU) using round-robin arbitration with valid/ready handshakes. Keeps a per-register pending scoreboard so the issue stage stalls on RAW/WAW hazards. Sits between EXU/LSU outputs and the `RegisterFile` write port (`wen`, `waddr`, `wdata`).

---
 rtl/rf_pkg.sv | 14 +
 rtl/rr_arb2.sv | 43 ++++
 rtl/rf_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file write-back path.
package rf_pkg;

   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_DATA_WIDTH = 64;
   localparam int RF_NUM        = 32;

   // Requester index; doubles as the bit position in req/gnt vectors.
   typedef enum logic {
      WB_EXU = 1'b0,
      WB_LSU = 1'b1
   } wb_req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, pointer names the requester
// that wins when both ask, and moves to the loser after every accepted grant.
module rr_arb2
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   wb_req_e ptr_q;
   wb_req_e ptr_d;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      gnt = req;
      if (req[WB_EXU] && req[WB_LSU]) begin
         gnt         = 2'b00;
         gnt[ptr_q]  = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && (gnt != 2'b00)) begin
         ptr_d = gnt[WB_EXU] ? WB_LSU : WB_EXU;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= WB_LSU;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back controller: round-robin EXU/LSU onto the single
// write port, plus a pending-write scoreboard that stalls issue on RAW/WAW.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,

   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,

   input  logic                  iss_valid,
   input  logic                  iss_wr,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   input  logic [ADDR_WIDTH-1:0] iss_rs1,
   input  logic [ADDR_WIDTH-1:0] iss_rs2,
   output logic                  iss_stall,

   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [1:0]            req;
   logic [1:0]            gnt;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;

   logic                  rf_wen_q,   rf_wen_d;
   logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic [NUM_REGS-1:0]   pending_q,  pending_d;
   logic                  iss_set;

   assign req = {lsu_valid, exu_valid};

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (accept),
      .gnt     (gnt)
   );

   assign exu_ready = gnt[WB_EXU];
   assign lsu_ready = gnt[WB_LSU];
   assign accept    = |gnt;

   always_comb begin
      sel_rd   = exu_rd;
      sel_data = exu_data;
      if (gnt[WB_LSU]) begin
         sel_rd   = lsu_rd;
         sel_data = lsu_data;
      end
   end

   // A transfer to x0 is consumed but never reaches the register file.
   always_comb begin
      rf_wen_d   = accept && (sel_rd != '0);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (accept) begin
         rf_waddr_d = sel_rd;
         rf_wdata_d = sel_data;
      end
   end

   assign iss_stall = iss_valid &&
                      (pending_q[iss_rs1] || pending_q[iss_rs2] ||
                       (iss_wr && pending_q[iss_rd]));

   assign iss_set = iss_valid && iss_wr && !iss_stall && (iss_rd != '0);

   // Clear first, then set, so a same-index set overrides the commit's clear.
   always_comb begin
      pending_d = pending_q;
      if (rf_wen_q) begin
         pending_d[rf_waddr_q] = 1'b0;
      end
      if (iss_set) begin
         pending_d[iss_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset along
   // with the write register; stale pending bits would deadlock issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         pending_q  <= '0;
      end else begin
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         pending_q  <= pending_d;
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed stimulus with a write-back
// scoreboard that expects each accepted transfer on the register-file port.
module tb_rf_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          exu_valid, exu_ready;
   logic [AW-1:0] exu_rd;
   logic [DW-1:0] exu_data;
   logic          lsu_valid, lsu_ready;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_data;
   logic          iss_valid, iss_wr, iss_stall;
   logic [AW-1:0] iss_rd, iss_rs1, iss_rs2;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_exp_t;

   wb_exp_t sb_q[$];
   wb_exp_t mon_e;
   int      n_cmp = 0;
   int      n_mis = 0;

   rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .exu_valid (exu_valid),
      .exu_ready (exu_ready),
      .exu_rd    (exu_rd),
      .exu_data  (exu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .iss_valid (iss_valid),
      .iss_wr    (iss_wr),
      .iss_rd    (iss_rd),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_stall (iss_stall),
      .rf_wen    (rf_wen),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
      iss_valid = 1'b1;
      iss_wr    = wr;
      iss_rd    = rd;
      iss_rs1   = rs1;
      iss_rs2   = rs2;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic exu_write(input logic [AW-1:0] rd, input logic [DW-1:0] d);
      exu_valid = 1'b1;
      exu_rd    = rd;
      exu_data  = d;
      @(negedge clk);
      check("exu_ready", 64'(exu_ready), 64'd1);
      if (rd != '0) sb_q.push_back(wb_exp_t'{addr: rd, data: d});
      cyc();
      exu_valid = 1'b0;
   endtask

   // Every rf_wen pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && rf_wen) begin
         check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("wb_waddr", 64'(rf_waddr), 64'(mon_e.addr));
            check("wb_wdata", rf_wdata, mon_e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  e_cnt;
      int  l_cnt;
      bit  exp_lsu;

      rst = 1'b1;
      exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state, with an issue reading several sources.
      issue(1'b1, 5'd3, 5'd5, 5'd6);
      @(negedge clk);
      check("rst_wen",   64'(rf_wen),    64'd0);
      check("rst_waddr", 64'(rf_waddr),  64'd0);
      check("rst_wdata", rf_wdata,       64'd0);
      check("rst_stall", 64'(iss_stall), 64'd0);
      check("rst_exu_ready", 64'(exu_ready), 64'd0);
      check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      cyc();
      iss_valid = 1'b0;
      // Clear the pending bit on x3 just set by that issue.
      exu_write(5'd3, 64'h33);
      cyc();

      // Re-reset so contention starts from the LSU-priority pointer.
      rst = 1'b1;
      cyc();
      rst = 1'b0;

      // Contention: both valid until four transfers each, strict alternation.
      e_cnt = 0;
      l_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         exu_valid = (e_cnt < 4);
         exu_rd    = AW'(1 + e_cnt);
         exu_data  = 64'h100 + 64'(e_cnt);
         lsu_valid = (l_cnt < 4);
         lsu_rd    = AW'(11 + l_cnt);
         lsu_data  = 64'h200 + 64'(l_cnt);
         @(negedge clk);
         exp_lsu = (c % 2 == 0);
         check("cont_lsu_ready", 64'(lsu_ready), 64'(exp_lsu));
         check("cont_exu_ready", 64'(exu_ready), 64'(!exp_lsu));
         if (exp_lsu) sb_q.push_back(wb_exp_t'{addr: AW'(11 + c / 2), data: 64'h200 + 64'(c / 2)});
         else         sb_q.push_back(wb_exp_t'{addr: AW'(1 + c / 2),  data: 64'h100 + 64'(c / 2)});
         if (exu_ready) e_cnt++;
         if (lsu_ready) l_cnt++;
         cyc();
      end
      exu_valid = 1'b0;
      lsu_valid = 1'b0;

      // Lone requester is granted back-to-back, pointer notwithstanding.
      for (int i = 0; i < 3; i++) begin
         lsu_valid = 1'b1;
         lsu_rd    = AW'(20 + i);
         lsu_data  = 64'hA00 + 64'(i);
         @(negedge clk);
         check("solo_lsu_ready", 64'(lsu_ready), 64'd1);
         sb_q.push_back(wb_exp_t'{addr: AW'(20 + i), data: 64'hA00 + 64'(i)});
         cyc();
      end
      lsu_valid = 1'b0;
      cyc();

      // Single EXU write; the monitor checks the N+1 write port values.
      exu_write(5'd5, 64'hDEAD);
      @(negedge clk);
      check("single_wen", 64'(rf_wen), 64'd1);
      cyc();
      @(negedge clk);
      check("single_wen_drop", 64'(rf_wen), 64'd0);
      cyc();

      // RAW: producer issues rd=7, consumer reading x7 stalls until commit.
      issue(1'b1, 5'd7, 5'd0, 5'd0);
      @(negedge clk);
      check("raw_producer_stall", 64'(iss_stall), 64'd0);
      cyc();
      issue(1'b0, 5'd0, 5'd7, 5'd0);
      @(negedge clk);
      check("raw_consumer_stall", 64'(iss_stall), 64'd1);
      cyc();
      exu_write(5'd7, 64'h7777);
      @(negedge clk);
      check("raw_stall_during_wen", 64'(iss_stall), 64'd1);
      cyc();
      @(negedge clk);
      check("raw_stall_released", 64'(iss_stall), 64'd0);
      cyc();
      issue(1'b0, 5'd0, 5'd0, 5'd7);
      @(negedge clk);
      check("raw_rs2_clear", 64'(iss_stall), 64'd0);
      cyc();
      iss_valid = 1'b0;

      // x0: issue to x0 never marks pending; EXU write to x0 is consumed silently.
      issue(1'b1, 5'd0, 5'd0, 5'd0);
      cyc();
      issue(1'b1, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      check("x0_no_pending", 64'(iss_stall), 64'd0);
      cyc();
      iss_valid = 1'b0;
      exu_write(5'd0, 64'hBAD);
      @(negedge clk);
      check("x0_no_wen", 64'(rf_wen), 64'd0);
      cyc();

      // WAW: second write to pending x9 stalls.
      issue(1'b1, 5'd9, 5'd0, 5'd0);
      @(negedge clk);
      check("waw_first_stall", 64'(iss_stall), 64'd0);
      cyc();
      issue(1'b1, 5'd9, 5'd1, 5'd2);
      @(negedge clk);
      check("waw_second_stall", 64'(iss_stall), 64'd1);
      cyc();
      iss_valid = 1'b0;
      exu_write(5'd9, 64'h9001);
      cyc();
      // x9 now clear; an unsolicited write to x9 commits while issue sets x9.
      exu_write(5'd9, 64'h9002);
      issue(1'b1, 5'd9, 5'd0, 5'd0);
      @(negedge clk);
      check("setclr_wen", 64'(rf_wen), 64'd1);
      check("setclr_issue_stall", 64'(iss_stall), 64'd0);
      cyc();
      issue(1'b0, 5'd0, 5'd9, 5'd0);
      @(negedge clk);
      check("setclr_set_wins", 64'(iss_stall), 64'd1);
      cyc();
      iss_valid = 1'b0;
      exu_write(5'd9, 64'h9003);
      cyc();

      // Async reset mid-flight: pending x4 and an in-flight write both vanish.
      issue(1'b1, 5'd4, 5'd0, 5'd0);
      cyc();
      iss_valid = 1'b0;
      exu_write(5'd3, 64'hABC);
      @(negedge clk);
      #2;
      check("arst_pre_wen", 64'(rf_wen), 64'd1);
      rst = 1'b1;
      #1;
      check("arst_wen_drop",   64'(rf_wen),   64'd0);
      check("arst_waddr_zero", 64'(rf_waddr), 64'd0);
      check("arst_wdata_zero", rf_wdata,      64'd0);
      cyc();
      rst = 1'b0;
      issue(1'b1, 5'd4, 5'd4, 5'd0);
      @(negedge clk);
      check("arst_pending_clear", 64'(iss_stall), 64'd0);
      cyc();
      iss_valid = 1'b0;
      cyc();

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
